fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the program counter and the flash read port.
- Issues one flash read per PC value and delivers the fetched word to the decoder over a valid/ready handshake.
- Then commands the PC to increment, or to load a branch target.
- Sits between program_counter, the flash read interface and the decode stage. It is the only driver of pc_inc/pc_load/pc_next.

Parameters:
- ADDR_WIDTH, 12, width of PC and flash address.
- INSTR_WIDTH, 16, width of flash read data / instruction.
- BOOT_LIMIT, 12'h200, first address outside the bootstrap region.
- TIMEOUT_CYC, 15, max WAIT cycles before a read is re-issued (must be ≥1).

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  asynchronous, active-low reset.
- pc_out  in  ADDR_WIDTH  current PC.
- bootstrapping  in  1  PC is inside the bootstrap region.
- pc_inc  out  1  increment request to PC.
- pc_load  out  1  load request to PC.
- pc_next  out  ADDR_WIDTH  load target to PC.
- flash_ready  in  1  flash idle; PC updates and requests only take effect when 1.
- flash_req  out  1  one-cycle read strobe.
- flash_addr  out  ADDR_WIDTH  read address.
- flash_rvalid  in  1  read data valid, one-cycle pulse.
- flash_rdata  in  INSTR_WIDTH  read data.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts.
- instr  out  INSTR_WIDTH  fetched instruction.
- instr_addr  out  ADDR_WIDTH  address of instr.
- instr_boot  out  1  instr was fetched inside the bootstrap region.
- halt  in  1  hold off new requests.
- branch_req  in  1  one-cycle branch request.
- branch_target  in  ADDR_WIDTH  branch destination.
- fetch_err  out  1  sticky: at least one timeout occurred.
- illegal_branch  out  1  sticky: rejected branch into the bootstrap region.

Behaviour:
- Reset (arst_n=0, asynchronous):
  - State = START.
  - Outputs at reset: pc_inc=0, pc_load=0, pc_next=0, flash_req=0, flash_addr=0, instr_valid=0, instr=0, instr_addr=0, instr_boot=0, fetch_err=0, illegal_branch=0.
  - Internal registers at reset: branch pending bit=0, target=0, timeout counter=0.
- Reset asserted mid-operation aborts everything. Any late flash_rvalid arriving after reset release while in START/FETCH is ignored.
- States:
  - START: one cycle, then FETCH.
  - FETCH:
    - If branch pending, go to UPDATE.
    - Else if halt=0 and flash_ready=1: drive flash_req=1 and flash_addr=pc_out for exactly one cycle, latch instr_boot=bootstrapping, clear the counter, go to WAIT.
    - Else stay.
  - WAIT:
    - On flash_rvalid:
      - If branch pending, discard data and go to UPDATE.
      - Else register instr=flash_rdata and instr_addr=flash_addr, set instr_valid=1 next cycle, go to DELIVER.
    - Each cycle without rvalid, increment the counter. On reaching TIMEOUT_CYC, set fetch_err=1 and go to FETCH (re-issue).
  - DELIVER:
    - instr_valid=1 and instr are stable until instr_valid & instr_ready.
    - On the handshake, drop instr_valid next cycle and go to UPDATE.
    - If a branch is pending, drop instr_valid without a handshake and go to UPDATE.
  - UPDATE:
    - If branch pending: hold pc_load=1, pc_next=target. Otherwise hold pc_inc=1.
    - Hold the request until a cycle with flash_ready=1. In that cycle the PC updates; clear the pending bit if loading. Next cycle deassert and go to FETCH.
    - pc_inc and pc_load are never high together.
- Branch capture:
  - branch_req is sampled in every state except START.
  - If bootstrapping=0 and branch_target < BOOT_LIMIT: the branch is ignored and illegal_branch=1 (sticky).
  - Otherwise set the pending bit and latch the target; a later accepted branch before UPDATE completes overwrites the target.
  - branch_req arriving during DELIVER in the same cycle as an instr handshake: the handshake completes (instruction consumed), then UPDATE performs the load, not an increment.
- Latency: from FETCH with flash_ready=1 and rvalid returned N cycles after flash_req, instr_valid rises N+1 cycles after flash_req.
- Wrap-around:
  - pc_out=all-ones increments to 0 with no special handling.
  - instr_boot follows bootstrapping at request time.
  - Branches to BOOT_LIMIT-1 from outside the boot region are illegal; a branch to BOOT_LIMIT is legal.
- halt only blocks FETCH. An outstanding read completes and is delivered normally.
- Sticky flags clear only on reset.

Test Plan:
- Sequential fetch: PC=0x000, flash returns rdata=0x1234 two cycles after req, instr_ready=1 → instr_valid with instr=0x1234, instr_addr=0x000, instr_boot=1; one pc_inc pulse; next flash_addr=0x001.
- Backpressure: instr_ready=0 for 5 cycles → instr/instr_addr stable, no pc_inc, no second flash_req until the handshake.
- Branch during WAIT: PC=0x210, branch_req target=0x300 before rvalid → returned data discarded, no instr_valid, pc_load=1 with pc_next=0x300, next flash_addr=0x300.
- Illegal branch: PC=0x250 (bootstrapping=0), branch_target=0x1F0 → no pc_load, illegal_branch=1, fetch continues at 0x251.
- Timeout: flash never asserts rvalid → after 15 WAIT cycles fetch_err=1 and flash_req re-issued for the same address; later rvalid delivered normally.
- flash_ready low in UPDATE for 3 cycles → pc_inc held high for all 4 cycles; exactly one PC increment; reset pulse mid-WAIT returns all outputs to 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: issues one flash read per PC value, hands the word to decode
// over valid/ready, then steps the PC or loads a captured branch target.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BOOT_LIMIT  = 12'h200,
    parameter int                    TIMEOUT_CYC = 15
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [ADDR_WIDTH-1:0]  pc_out,
    input  logic                   bootstrapping,
    output logic                   pc_inc,
    output logic                   pc_load,
    output logic [ADDR_WIDTH-1:0]  pc_next,
    input  logic                   flash_ready,
    output logic                   flash_req,
    output logic [ADDR_WIDTH-1:0]  flash_addr,
    input  logic                   flash_rvalid,
    input  logic [INSTR_WIDTH-1:0] flash_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_addr,
    output logic                   instr_boot,
    input  logic                   halt,
    input  logic                   branch_req,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   fetch_err,
    output logic                   illegal_branch
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_WAIT,
        S_DELIVER,
        S_UPDATE
    } state_t;

    state_t                state;
    logic                  br_pend;
    logic [ADDR_WIDTH-1:0] br_tgt;
    logic [CNT_W-1:0]      cnt;

    logic                  br_take;
    logic                  br_bad;
    logic                  br_acc;
    logic                  pend_nxt;
    logic [ADDR_WIDTH-1:0] tgt_nxt;

    // A branch accepted this cycle must already steer the UPDATE we are entering.
    always_comb begin
        br_take  = 1'b0;
        br_bad   = 1'b0;
        br_acc   = 1'b0;
        pend_nxt = br_pend;
        tgt_nxt  = br_tgt;
        br_take  = branch_req && (state != S_START);
        br_bad   = br_take && !bootstrapping && (branch_target < BOOT_LIMIT);
        br_acc   = br_take && !br_bad;
        if (br_acc) begin
            pend_nxt = 1'b1;
            tgt_nxt  = branch_target;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state          <= S_START;
            br_pend        <= 1'b0;
            br_tgt         <= '0;
            cnt            <= '0;
            pc_inc         <= 1'b0;
            pc_load        <= 1'b0;
            pc_next        <= '0;
            flash_req      <= 1'b0;
            flash_addr     <= '0;
            instr_valid    <= 1'b0;
            instr          <= '0;
            instr_addr     <= '0;
            instr_boot     <= 1'b0;
            fetch_err      <= 1'b0;
            illegal_branch <= 1'b0;
        end else begin
            flash_req <= 1'b0;
            if (br_bad) begin
                illegal_branch <= 1'b1;
            end
            if (br_acc) begin
                br_pend <= 1'b1;
                br_tgt  <= branch_target;
            end

            case (state)
                S_START: begin
                    state <= S_FETCH;
                end

                S_FETCH: begin
                    if (br_pend) begin
                        pc_load <= 1'b1;
                        pc_inc  <= 1'b0;
                        pc_next <= tgt_nxt;
                        state   <= S_UPDATE;
                    end else if (!halt && flash_ready) begin
                        flash_req  <= 1'b1;
                        flash_addr <= pc_out;
                        instr_boot <= bootstrapping;
                        cnt        <= '0;
                        state      <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (flash_rvalid) begin
                        if (br_pend) begin
                            pc_load <= 1'b1;
                            pc_inc  <= 1'b0;
                            pc_next <= tgt_nxt;
                            state   <= S_UPDATE;
                        end else begin
                            instr       <= flash_rdata;
                            instr_addr  <= flash_addr;
                            instr_valid <= 1'b1;
                            state       <= S_DELIVER;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        fetch_err <= 1'b1;
                        state     <= S_FETCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DELIVER: begin
                    if ((instr_valid && instr_ready) || br_pend) begin
                        instr_valid <= 1'b0;
                        pc_load     <= pend_nxt;
                        pc_inc      <= !pend_nxt;
                        pc_next     <= tgt_nxt;
                        state       <= S_UPDATE;
                    end
                end

                S_UPDATE: begin
                    // The PC acts on the request in the first cycle flash_ready is high.
                    if (flash_ready) begin
                        pc_inc  <= 1'b0;
                        pc_load <= 1'b0;
                        if (pc_load && !br_acc) begin
                            br_pend <= 1'b0;
                        end
                        state <= S_FETCH;
                    end else begin
                        pc_load <= pend_nxt;
                        pc_inc  <= !pend_nxt;
                        pc_next <= tgt_nxt;
                    end
                end

                default: begin
                    state <= S_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC and a fixed-latency flash responder.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [11:0] pc = 12'h000;
    logic        bootstrapping;
    logic        pc_inc, pc_load;
    logic [11:0] pc_next;
    logic        flash_ready;
    logic        flash_req;
    logic [11:0] flash_addr;
    logic        flash_rvalid = 1'b0;
    logic [15:0] flash_rdata = 16'h0000;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [11:0] instr_addr;
    logic        instr_boot;
    logic        halt;
    logic        branch_req;
    logic [11:0] branch_target;
    logic        fetch_err, illegal_branch;

    logic        pc_force = 1'b0;
    logic [11:0] pc_force_val = 12'h000;
    int          lat = 2;
    logic        never = 1'b0;
    int          wcnt = 0;
    logic [11:0] req_addr = 12'h000;

    int n_chk = 0;
    int n_fail = 0;
    int mon_inc, mon_load, mon_valid, mon_req;
    logic [11:0] load_next;

    fetch_sequencer #(
        .ADDR_WIDTH (12),
        .INSTR_WIDTH(16),
        .BOOT_LIMIT (12'h200),
        .TIMEOUT_CYC(15)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .pc_out        (pc),
        .bootstrapping (bootstrapping),
        .pc_inc        (pc_inc),
        .pc_load       (pc_load),
        .pc_next       (pc_next),
        .flash_ready   (flash_ready),
        .flash_req     (flash_req),
        .flash_addr    (flash_addr),
        .flash_rvalid  (flash_rvalid),
        .flash_rdata   (flash_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_addr    (instr_addr),
        .instr_boot    (instr_boot),
        .halt          (halt),
        .branch_req    (branch_req),
        .branch_target (branch_target),
        .fetch_err     (fetch_err),
        .illegal_branch(illegal_branch)
    );

    always #5 clk = ~clk;

    assign bootstrapping = (pc < 12'h200);

    function automatic logic [15:0] mem(input logic [11:0] a);
        return (a == 12'h000) ? 16'h1234 : {4'hC, a};
    endfunction

    // Program counter model: acts on a request only while flash_ready is high.
    always @(posedge clk) begin
        if (pc_force)                     pc <= pc_force_val;
        else if (flash_ready && pc_load)  pc <= pc_next;
        else if (flash_ready && pc_inc)   pc <= pc + 12'd1;
    end

    // Flash returns rvalid 'lat' cycles after the request cycle.
    always @(posedge clk) begin
        flash_rvalid <= 1'b0;
        if (flash_req && !never) begin
            req_addr <= flash_addr;
            if (lat <= 1) begin
                flash_rvalid <= 1'b1;
                flash_rdata  <= mem(flash_addr);
                wcnt         <= 0;
            end else begin
                wcnt <= lat - 1;
            end
        end else if (wcnt > 0) begin
            wcnt <= wcnt - 1;
            if (wcnt == 1) begin
                flash_rvalid <= 1'b1;
                flash_rdata  <= mem(req_addr);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clr_mon();
        mon_inc = 0; mon_load = 0; mon_valid = 0; mon_req = 0; load_next = 12'h000;
    endtask

    task automatic step();
        @(negedge clk);
        if (pc_inc) mon_inc++;
        if (pc_load) begin
            mon_load++;
            load_next = pc_next;
        end
        if (instr_valid) mon_valid++;
        if (flash_req) mon_req++;
    endtask

    task automatic run_until(input bit want_valid, input int maxc, output int cyc);
        cyc = 0;
        repeat (maxc) begin
            step();
            cyc++;
            if (want_valid ? instr_valid : flash_req) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_%s: not seen within %0d cycles", want_valid ? "instr_valid" : "flash_req", maxc);
    endtask

    task automatic park();
        halt = 1'b1; instr_ready = 1'b1; flash_ready = 1'b1; branch_req = 1'b0;
        repeat (40) step();
    endtask

    task automatic set_pc(input logic [11:0] v);
        pc_force = 1'b1; pc_force_val = v;
        step();
        pc_force = 1'b0;
    endtask

    typedef struct {
        logic [11:0] pc;
        int          lat;
        logic [15:0] e_instr;
        logic        e_boot;
        logic [11:0] e_next;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int cyc;
        int hi_cnt;
        int bad;

        vecs[0] = '{pc: 12'h000, lat: 2, e_instr: 16'h1234, e_boot: 1'b1, e_next: 12'h001};
        vecs[1] = '{pc: 12'h1FF, lat: 1, e_instr: 16'hC1FF, e_boot: 1'b1, e_next: 12'h200};
        vecs[2] = '{pc: 12'h200, lat: 3, e_instr: 16'hC200, e_boot: 1'b0, e_next: 12'h201};
        vecs[3] = '{pc: 12'hFFF, lat: 4, e_instr: 16'hCFFF, e_boot: 1'b0, e_next: 12'h000};

        arst_n = 1'b0; halt = 1'b1; instr_ready = 1'b1; flash_ready = 1'b1;
        branch_req = 1'b0; branch_target = 12'h000;
        clr_mon();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {pc_inc, pc_load, pc_next, flash_req, flash_addr, instr_valid, instr,
                              instr_addr, instr_boot, fetch_err, illegal_branch}, 64'd0);
        chk("reset_instr_valid", instr_valid, 1'b0);
        arst_n = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 4; i++) begin
            park();
            set_pc(vecs[i].pc);
            lat = vecs[i].lat;
            halt = 1'b0;
            clr_mon();
            run_until(1'b0, 20, cyc);
            chk("seq_flash_addr", flash_addr, vecs[i].pc);
            run_until(1'b1, 20, cyc);
            chk("seq_latency", cyc, vecs[i].lat + 1);
            chk("seq_instr", instr, vecs[i].e_instr);
            chk("seq_instr_addr", instr_addr, vecs[i].pc);
            chk("seq_instr_boot", instr_boot, vecs[i].e_boot);
            clr_mon();
            run_until(1'b0, 20, cyc);
            chk("seq_inc_pulses", mon_inc, 1);
            chk("seq_no_load", mon_load, 0);
            chk("seq_next_addr", flash_addr, vecs[i].e_next);
        end

        // Backpressure: decode stalls for 5 cycles
        park();
        set_pc(12'h010);
        lat = 2; instr_ready = 1'b0; halt = 1'b0;
        run_until(1'b1, 20, cyc);
        clr_mon();
        bad = 0;
        repeat (5) begin
            step();
            if (!instr_valid || instr !== 16'hC010 || instr_addr !== 12'h010) bad++;
        end
        chk("bp_stable", bad, 0);
        chk("bp_no_inc", mon_inc, 0);
        chk("bp_no_req", mon_req, 0);
        instr_ready = 1'b1;
        run_until(1'b0, 20, cyc);
        chk("bp_next_addr", flash_addr, 12'h011);

        // Branch while the read is outstanding
        park();
        set_pc(12'h210);
        lat = 6; halt = 1'b0;
        run_until(1'b0, 20, cyc);
        branch_req = 1'b1; branch_target = 12'h300;
        step();
        branch_req = 1'b0;
        clr_mon();
        run_until(1'b0, 30, cyc);
        chk("brw_no_valid", mon_valid, 0);
        chk("brw_load", mon_load, 1);
        chk("brw_pc_next", load_next, 12'h300);
        chk("brw_no_inc", mon_inc, 0);
        chk("brw_next_addr", flash_addr, 12'h300);

        // Branch into the boot region from outside is rejected
        chk("illegal_before", illegal_branch, 1'b0);
        park();
        set_pc(12'h250);
        lat = 2; halt = 1'b0;
        run_until(1'b0, 20, cyc);
        branch_req = 1'b1; branch_target = 12'h1F0;
        step();
        branch_req = 1'b0;
        chk("illegal_flag", illegal_branch, 1'b1);
        clr_mon();
        run_until(1'b0, 30, cyc);
        chk("illegal_delivered", mon_valid > 0, 1'b1);
        chk("illegal_no_load", mon_load, 0);
        chk("illegal_next_addr", flash_addr, 12'h251);

        // Branch to BOOT_LIMIT, same cycle as the handshake
        park();
        set_pc(12'h260);
        lat = 2; halt = 1'b0;
        run_until(1'b1, 20, cyc);
        branch_req = 1'b1; branch_target = 12'h200;
        clr_mon();
        step();
        branch_req = 1'b0;
        chk("hsbr_consumed", instr_valid, 1'b0);
        run_until(1'b0, 30, cyc);
        chk("hsbr_load", mon_load, 1);
        chk("hsbr_pc_next", load_next, 12'h200);
        chk("hsbr_no_inc", mon_inc, 0);
        chk("hsbr_next_addr", flash_addr, 12'h200);

        // Flash never answers: timeout and re-issue
        park();
        set_pc(12'h020);
        never = 1'b1; lat = 2;
        chk("to_err_before", fetch_err, 1'b0);
        halt = 1'b0;
        run_until(1'b0, 20, cyc);
        run_until(1'b0, 40, cyc);
        never = 1'b0;
        chk("to_reissue_gap", cyc, 16);
        chk("to_fetch_err", fetch_err, 1'b1);
        chk("to_same_addr", flash_addr, 12'h020);
        run_until(1'b1, 20, cyc);
        chk("to_latency", cyc, 3);
        chk("to_instr", instr, 16'hC020);

        // flash_ready low for 3 cycles in UPDATE
        park();
        set_pc(12'h030);
        lat = 1; halt = 1'b0;
        run_until(1'b1, 20, cyc);
        flash_ready = 1'b0;
        clr_mon();
        repeat (3) step();
        step();
        flash_ready = 1'b1;
        hi_cnt = mon_inc;
        step();
        chk("upd_inc_cycles", hi_cnt, 4);
        chk("upd_inc_dropped", pc_inc, 1'b0);
        chk("upd_no_req", mon_req, 0);
        chk("upd_pc", pc, 12'h031);

        // Reset pulse mid-WAIT
        park();
        set_pc(12'h040);
        never = 1'b1; halt = 1'b0;
        run_until(1'b0, 20, cyc);
        step();
        step();
        arst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {pc_inc, pc_load, pc_next, flash_req, flash_addr, instr_valid, instr,
                                instr_addr, instr_boot, fetch_err, illegal_branch}, 64'd0);
        step();
        arst_n = 1'b1;
        never = 1'b0;
        run_until(1'b0, 20, cyc);
        chk("rst_refetch_addr", flash_addr, 12'h040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
